// File: rtl/arm7tdmi_jtag_scan_master_if.sv
// Command/response channel between the debug host bridge and the JTAG scan master.
//   cmd_valid/cmd_ready : command handshake, one command per valid&ready cycle
//   cmd_op              : 00 TAP_RESET, 01 SCAN_IR, 10 SCAN_DR, 11 IDLE_CLKS
//   cmd_len             : bit count (scans) or TCK count (IDLE_CLKS)
//   cmd_data            : TDI bits, LSB shifted first
//   rsp_valid/rsp_data  : one-cycle completion pulse with captured TDO bits
//   busy                : sequence in progress
// Modport master is the host side, modport slave is the scan master side.
interface arm7tdmi_jtag_scan_master_if #(
    parameter int MAX_LEN = 32
);
    logic               cmd_valid;
    logic               cmd_ready;
    logic [1:0]         cmd_op;
    logic [5:0]         cmd_len;
    logic [MAX_LEN-1:0] cmd_data;
    logic               rsp_valid;
    logic [MAX_LEN-1:0] rsp_data;
    logic               busy;

    modport master (
        output cmd_valid, cmd_op, cmd_len, cmd_data,
        input  cmd_ready, rsp_valid, rsp_data, busy
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_len, cmd_data,
        output cmd_ready, rsp_valid, rsp_data, busy
    );
endinterface

// File: rtl/arm7tdmi_jtag_scan_master.sv
// Host-side JTAG sequencer for the on-chip debug TAP. Accepts one scan command
// at a time, generates TCK/TMS/TDI, captures TDO and returns one response.
// Ports:
//   clk, rst_n         : system clock, asynchronous active-low reset
//   host (slave)       : command/response channel (see interface file)
//   jtag_tck/tms/tdi   : generated JTAG pins, TCK idles low
//   jtag_tdo           : TDO from the TAP, sampled just before each TCK rise
module arm7tdmi_jtag_scan_master #(
    parameter int CLK_DIV = 4,
    parameter int MAX_LEN = 32
) (
    input  logic                              clk,
    input  logic                              rst_n,
    arm7tdmi_jtag_scan_master_if.slave        host,
    output logic                              jtag_tck,
    output logic                              jtag_tms,
    output logic                              jtag_tdi,
    input  logic                              jtag_tdo
);
    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W  = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int LEN_W  = 6;
    localparam int STEP_W = $clog2(MAX_LEN + 64);

    localparam logic [1:0] OP_TAP_RESET = 2'b00;
    localparam logic [1:0] OP_SCAN_IR   = 2'b01;
    localparam logic [1:0] OP_SCAN_DR   = 2'b10;
    localparam logic [1:0] OP_IDLE_CLKS = 2'b11;

    typedef enum logic [2:0] {IDLE, HEAD, SHIFT, TAIL, RESP} state_t;

    state_t             state, state_nxt, seg_inc;
    logic [DIV_W-1:0]   div_cnt, div_nxt;
    logic [STEP_W-1:0]  step, step_nxt, step_inc;
    logic [STEP_W-1:0]  total, total_nxt;
    logic [BIT_W-1:0]   bit_idx, bit_nxt, bit_inc;
    logic [1:0]         op, op_nxt;
    logic [LEN_W-1:0]   len, len_nxt, len_in;
    logic               tck_nxt, tms_nxt, tdi_nxt;
    logic               rsp_valid, rsp_valid_nxt;
    logic [MAX_LEN-1:0] rsp_data, rsp_data_nxt;
    logic [MAX_LEN-1:0] data, cap;
    logic               accept, capture;

    // Scans shift at least one bit and never more than the data width.
    function automatic logic [LEN_W-1:0] clamp_len(input logic [1:0] o, input logic [LEN_W-1:0] l);
        logic [LEN_W-1:0] r;
        r = l;
        if (o == OP_SCAN_IR || o == OP_SCAN_DR) begin
            if (l == '0) r = LEN_W'(1);
            else if (l > LEN_W'(MAX_LEN)) r = LEN_W'(MAX_LEN);
        end
        return r;
    endfunction

    function automatic logic [STEP_W-1:0] tck_total(input logic [1:0] o, input logic [LEN_W-1:0] l);
        logic [STEP_W-1:0] r;
        case (o)
            OP_TAP_RESET: r = STEP_W'(6);
            OP_SCAN_IR:   r = STEP_W'(l) + STEP_W'(6);
            OP_SCAN_DR:   r = STEP_W'(l) + STEP_W'(5);
            default:      r = STEP_W'(l);
        endcase
        return r;
    endfunction

    // TCKs before the first shift bit: RTI->Shift-IR takes 4, RTI->Shift-DR takes 3.
    function automatic logic [STEP_W-1:0] head_len(input logic [1:0] o);
        return (o == OP_SCAN_IR) ? STEP_W'(4) : STEP_W'(3);
    endfunction

    function automatic state_t seg_at(input logic [1:0] o, input logic [LEN_W-1:0] l,
                                      input logic [STEP_W-1:0] n);
        state_t r;
        if (o == OP_TAP_RESET || o == OP_IDLE_CLKS) r = HEAD;
        else if (n < head_len(o)) r = HEAD;
        else if (n < head_len(o) + STEP_W'(l)) r = SHIFT;
        else r = TAIL;
        return r;
    endfunction

    function automatic logic tms_at(input logic [1:0] o, input logic [LEN_W-1:0] l,
                                    input logic [STEP_W-1:0] n);
        logic [STEP_W-1:0] sh_end;
        logic              r;
        sh_end = head_len(o) + STEP_W'(l);
        case (o)
            OP_TAP_RESET: r = (n < STEP_W'(5));
            OP_IDLE_CLKS: r = 1'b0;
            default: begin
                if (n < head_len(o))
                    r = (n < ((o == OP_SCAN_IR) ? STEP_W'(2) : STEP_W'(1)));
                else if (n < sh_end)
                    r = (n == sh_end - 1'b1);   // last shift bit moves to Exit1
                else
                    r = (n == sh_end);          // Exit1 -> Update, then Update -> RTI
            end
        endcase
        return r;
    endfunction

    assign len_in = clamp_len(host.cmd_op, host.cmd_len);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            div_cnt   <= '0;
            step      <= '0;
            bit_idx   <= '0;
            op        <= OP_TAP_RESET;
            len       <= '0;
            total     <= '0;
            jtag_tck  <= 1'b0;
            jtag_tms  <= 1'b1;
            jtag_tdi  <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            state     <= state_nxt;
            div_cnt   <= div_nxt;
            step      <= step_nxt;
            bit_idx   <= bit_nxt;
            op        <= op_nxt;
            len       <= len_nxt;
            total     <= total_nxt;
            jtag_tck  <= tck_nxt;
            jtag_tms  <= tms_nxt;
            jtag_tdi  <= tdi_nxt;
            rsp_valid <= rsp_valid_nxt;
            rsp_data  <= rsp_data_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        div_nxt       = div_cnt;
        step_nxt      = step;
        bit_nxt       = bit_idx;
        op_nxt        = op;
        len_nxt       = len;
        total_nxt     = total;
        tck_nxt       = jtag_tck;
        tms_nxt       = jtag_tms;
        tdi_nxt       = jtag_tdi;
        rsp_valid_nxt = 1'b0;
        rsp_data_nxt  = rsp_data;
        accept        = 1'b0;
        capture       = 1'b0;
        step_inc      = step + 1'b1;
        bit_inc       = (state == SHIFT) ? bit_idx + 1'b1 : '0;
        seg_inc       = seg_at(op, len, step_inc);

        case (state)
            IDLE: begin
                if (host.cmd_valid) begin
                    accept    = 1'b1;
                    state_nxt = HEAD;
                    op_nxt    = host.cmd_op;
                    len_nxt   = len_in;
                    total_nxt = tck_total(host.cmd_op, len_in);
                    div_nxt   = '0;
                    step_nxt  = '0;
                    bit_nxt   = '0;
                    tck_nxt   = 1'b0;
                    // First TCK of every sequence except IDLE_CLKS leaves RTI with TMS=1.
                    tms_nxt   = (host.cmd_op != OP_IDLE_CLKS);
                    tdi_nxt   = 1'b0;
                end
            end
            HEAD, SHIFT, TAIL: begin
                if (total == '0) begin
                    state_nxt     = RESP;
                    rsp_valid_nxt = 1'b1;
                    rsp_data_nxt  = '0;
                end else if (div_cnt == DIV_W'(CLK_DIV - 1)) begin
                    div_nxt = '0;
                    tck_nxt = ~jtag_tck;
                    if (!jtag_tck) begin
                        capture = (state == SHIFT);
                    end else if (step == total - 1'b1) begin
                        state_nxt     = RESP;
                        rsp_valid_nxt = 1'b1;
                        rsp_data_nxt  = (op == OP_SCAN_IR || op == OP_SCAN_DR) ? cap : '0;
                    end else begin
                        step_nxt  = step_inc;
                        state_nxt = seg_inc;
                        tms_nxt   = tms_at(op, len, step_inc);
                        tdi_nxt   = (seg_inc == SHIFT) ? data[bit_inc] : 1'b0;
                        if (state == SHIFT && seg_inc == SHIFT) bit_nxt = bit_inc;
                    end
                end else begin
                    div_nxt = div_cnt + 1'b1;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Command data and TDO capture; cleared on accept so bits past len read 0.
    always_ff @(posedge clk) begin
        if (accept) begin
            data <= host.cmd_data;
            cap  <= '0;
        end else if (capture) begin
            cap[bit_idx] <= jtag_tdo;
        end
    end

    assign host.cmd_ready = (state == IDLE);
    assign host.busy      = (state != IDLE);
    assign host.rsp_valid = rsp_valid;
    assign host.rsp_data  = rsp_data;
endmodule

// File: tb/tb_arm7tdmi_jtag_scan_master.sv
// Bench for the JTAG scan master: two instances (CLK_DIV=4 and CLK_DIV=1),
// each driving a behavioural debug TAP with a 4-bit IR (IDCODE=1110, BYPASS
// for anything else) and IDCODE value 0x07926041.
module tb_arm7tdmi_jtag_scan_master;
    localparam logic [1:0] OP_RST  = 2'b00;
    localparam logic [1:0] OP_IR   = 2'b01;
    localparam logic [1:0] OP_DR   = 2'b10;
    localparam logic [1:0] OP_IDLE = 2'b11;
    localparam logic [31:0] IDCODE_VAL = 32'h0792_6041;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    arm7tdmi_jtag_scan_master_if #(.MAX_LEN(32)) hif0 ();
    arm7tdmi_jtag_scan_master_if #(.MAX_LEN(32)) hif1 ();

    wire tck_w [2];
    wire tms_w [2];
    wire tdi_w [2];
    wire tdo_w [2];

    arm7tdmi_jtag_scan_master #(.CLK_DIV(4), .MAX_LEN(32)) dut0 (
        .clk(clk), .rst_n(rst_n), .host(hif0),
        .jtag_tck(tck_w[0]), .jtag_tms(tms_w[0]), .jtag_tdi(tdi_w[0]), .jtag_tdo(tdo_w[0])
    );
    arm7tdmi_jtag_scan_master #(.CLK_DIV(1), .MAX_LEN(32)) dut1 (
        .clk(clk), .rst_n(rst_n), .host(hif1),
        .jtag_tck(tck_w[1]), .jtag_tms(tms_w[1]), .jtag_tdi(tdi_w[1]), .jtag_tdo(tdo_w[1])
    );

    typedef enum logic [3:0] {
        TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR, UPD_DR,
        SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR
    } tap_state_t;

    function automatic tap_state_t tap_next(input tap_state_t s, input logic t);
        case (s)
            TLR:    return t ? TLR    : RTI;
            RTI:    return t ? SEL_DR : RTI;
            SEL_DR: return t ? SEL_IR : CAP_DR;
            CAP_DR: return t ? EX1_DR : SH_DR;
            SH_DR:  return t ? EX1_DR : SH_DR;
            EX1_DR: return t ? UPD_DR : PAU_DR;
            PAU_DR: return t ? EX2_DR : PAU_DR;
            EX2_DR: return t ? UPD_DR : SH_DR;
            UPD_DR: return t ? SEL_DR : RTI;
            SEL_IR: return t ? TLR    : CAP_IR;
            CAP_IR: return t ? EX1_IR : SH_IR;
            SH_IR:  return t ? EX1_IR : SH_IR;
            EX1_IR: return t ? UPD_IR : PAU_IR;
            PAU_IR: return t ? EX2_IR : PAU_IR;
            EX2_IR: return t ? UPD_IR : SH_IR;
            default: return t ? SEL_DR : RTI;
        endcase
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_tap
        tap_state_t  st = TLR;
        logic [3:0]  ir = 4'b1110;
        logic [3:0]  ir_sr = 4'b0000;
        logic [31:0] dr_sr = 32'h0;
        logic        bp = 1'b0;
        logic        tdo_r = 1'b0;
        always @(posedge tck_w[g]) begin
            case (st)
                TLR:    ir <= 4'b1110;
                CAP_IR: ir_sr <= 4'b0001;
                SH_IR:  ir_sr <= {tdi_w[g], ir_sr[3:1]};
                UPD_IR: ir <= ir_sr;
                CAP_DR: if (ir == 4'b1110) dr_sr <= IDCODE_VAL; else bp <= 1'b0;
                SH_DR:  if (ir == 4'b1110) dr_sr <= {tdi_w[g], dr_sr[31:1]}; else bp <= tdi_w[g];
                default: ;
            endcase
            st <= tap_next(st, tms_w[g]);
        end
        always @(negedge tck_w[g])
            tdo_r <= (st == SH_IR) ? ir_sr[0] :
                     (st == SH_DR) ? ((ir == 4'b1110) ? dr_sr[0] : bp) : 1'b0;
        assign tdo_w[g] = tdo_r;
    end

    // Observers on instance 0: TCK count, TMS at each rise, accepts, responses.
    int          tck_cnt0 = 0;
    logic [63:0] tms_log0 = '0;
    int          acc_cnt = 0;
    int          acc_last = 0;
    int          rsp_cnt = 0;
    always @(posedge tck_w[0]) begin
        tck_cnt0 <= tck_cnt0 + 1;
        tms_log0 <= {tms_log0[62:0], tms_w[0]};
    end
    always @(posedge clk) begin
        if (hif0.cmd_valid && hif0.cmd_ready) begin
            acc_cnt  <= acc_cnt + 1;
            acc_last <= cyc + 1;
        end
        if (hif0.rsp_valid) rsp_cnt <= rsp_cnt + 1;
    end

    function automatic logic get_ready(input int sel);
        return (sel == 0) ? hif0.cmd_ready : hif1.cmd_ready;
    endfunction
    function automatic logic get_rsp_valid(input int sel);
        return (sel == 0) ? hif0.rsp_valid : hif1.rsp_valid;
    endfunction
    function automatic logic [31:0] get_rsp_data(input int sel);
        return (sel == 0) ? hif0.rsp_data : hif1.rsp_data;
    endfunction

    task automatic drive(input int sel, input logic v, input logic [1:0] op,
                         input logic [5:0] len, input logic [31:0] data);
        if (sel == 0) begin
            hif0.cmd_valid = v; hif0.cmd_op = op; hif0.cmd_len = len; hif0.cmd_data = data;
        end else begin
            hif1.cmd_valid = v; hif1.cmd_op = op; hif1.cmd_len = len; hif1.cmd_data = data;
        end
    endtask

    task automatic wait_ready(input int sel);
        int n = 0;
        @(negedge clk);
        while (!get_ready(sel) && n < 1000) begin @(negedge clk); n++; end
    endtask

    // Issues one command; lat = clk edges from accept edge to rsp_valid edge.
    task automatic run_cmd(input int sel, input logic [1:0] op, input logic [5:0] len,
                           input logic [31:0] data, output logic [31:0] rsp,
                           output int lat, output bit ok);
        int n;
        int e0;
        ok = 1'b0; rsp = '0; lat = -1;
        wait_ready(sel);
        drive(sel, 1'b1, op, len, data);
        @(negedge clk);
        e0 = cyc;
        drive(sel, 1'b0, 2'b00, 6'd0, 32'h0);
        n = 0;
        while (!get_rsp_valid(sel) && n < 2000) begin @(negedge clk); n++; end
        if (get_rsp_valid(sel)) begin
            ok  = 1'b1;
            lat = cyc - e0;
            rsp = get_rsp_data(sel);
        end
    endtask

    task automatic test_reset();
        logic [31:0] r; int lat; bit ok; int c0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({hif0.cmd_ready, hif0.busy, hif0.rsp_valid, tck_w[0], tms_w[0], tdi_w[0]} !== 6'b100010) begin
            failures++;
            $display("FAIL reset_outputs: got %b expected 100010",
                     {hif0.cmd_ready, hif0.busy, hif0.rsp_valid, tck_w[0], tms_w[0], tdi_w[0]});
        end
        checks++;
        if (hif0.rsp_data !== 32'h0) begin
            failures++; $display("FAIL reset_rsp_data: got %h expected 0", hif0.rsp_data);
        end
        rst_n = 1'b1;
        c0 = tck_cnt0;
        run_cmd(0, OP_RST, 6'd0, 32'h0, r, lat, ok);
        checks++;
        if (!ok || lat !== 48) begin
            failures++; $display("FAIL tap_reset_latency: got %0d (ok=%0d) expected 48", lat, ok);
        end
        checks++;
        if (tck_cnt0 - c0 !== 6) begin
            failures++; $display("FAIL tap_reset_tcks: got %0d expected 6", tck_cnt0 - c0);
        end
        checks++;
        if (tms_log0[5:0] !== 6'b111110) begin
            failures++; $display("FAIL tap_reset_tms: got %b expected 111110", tms_log0[5:0]);
        end
        checks++;
        if (r !== 32'h0) begin
            failures++; $display("FAIL tap_reset_rsp: got %h expected 0", r);
        end
    endtask

    task automatic test_idcode();
        logic [31:0] r; int lat; bit ok;
        run_cmd(0, OP_IR, 6'd4, 32'hE, r, lat, ok);
        checks++;
        if (!ok || r !== 32'h1 || lat !== 80) begin
            failures++; $display("FAIL idcode_ir: got rsp=%h lat=%0d expected rsp=1 lat=80", r, lat);
        end
        run_cmd(0, OP_DR, 6'd32, 32'h0, r, lat, ok);
        checks++;
        if (!ok || r !== IDCODE_VAL || lat !== 296) begin
            failures++; $display("FAIL idcode_dr: got rsp=%h lat=%0d expected rsp=07926041 lat=296", r, lat);
        end
    endtask

    task automatic test_bypass();
        logic [31:0] r; int lat; bit ok;
        run_cmd(0, OP_IR, 6'd4, 32'hF, r, lat, ok);
        checks++;
        if (!ok || r !== 32'h1) begin
            failures++; $display("FAIL bypass_ir: got %h expected 1", r);
        end
        run_cmd(0, OP_DR, 6'd8, 32'hAA, r, lat, ok);
        checks++;
        if (!ok || r !== 32'h54 || lat !== 104) begin
            failures++; $display("FAIL bypass_dr: got rsp=%h lat=%0d expected rsp=54 lat=104", r, lat);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] r; int lat; bit ok; int n; int acc0; int r_edge; int c0;
        wait_ready(0);
        acc0 = acc_cnt;
        drive(0, 1'b1, OP_DR, 6'd8, 32'h0F);
        n = 0;
        @(negedge clk);
        while (!hif0.rsp_valid && n < 2000) begin @(negedge clk); n++; end
        r_edge = cyc;
        r = hif0.rsp_data;
        checks++;
        if (acc_cnt - acc0 !== 1) begin
            failures++; $display("FAIL busy_ignore: got %0d accepts expected 1", acc_cnt - acc0);
        end
        checks++;
        if (!hif0.rsp_valid || r !== 32'h1E) begin
            failures++; $display("FAIL held_valid_rsp: got %h expected 1e", r);
        end
        n = 0;
        while (acc_cnt - acc0 < 2 && n < 10) begin @(negedge clk); n++; end
        drive(0, 1'b0, 2'b00, 6'd0, 32'h0);
        checks++;
        if (acc_cnt - acc0 !== 2 || acc_last - r_edge !== 2) begin
            failures++; $display("FAIL b2b_accept_gap: got %0d expected 2", acc_last - r_edge);
        end
        n = 0;
        while (!hif0.rsp_valid && n < 2000) begin @(negedge clk); n++; end
        checks++;
        if (!hif0.rsp_valid || hif0.rsp_data !== 32'h1E) begin
            failures++; $display("FAIL b2b_second_rsp: got %h expected 1e", hif0.rsp_data);
        end
        c0 = tck_cnt0;
        run_cmd(0, OP_IDLE, 6'd0, 32'h0, r, lat, ok);
        checks++;
        if (!ok || lat !== 1 || tck_cnt0 - c0 !== 0 || r !== 32'h0) begin
            failures++;
            $display("FAIL idle0: got lat=%0d tcks=%0d rsp=%h expected lat=1 tcks=0 rsp=0", lat, tck_cnt0 - c0, r);
        end
        c0 = tck_cnt0;
        run_cmd(0, OP_IDLE, 6'd3, 32'hFFFF_FFFF, r, lat, ok);
        checks++;
        if (!ok || lat !== 24 || tck_cnt0 - c0 !== 3 || tms_log0[2:0] !== 3'b000 || r !== 32'h0) begin
            failures++;
            $display("FAIL idle3: got lat=%0d tcks=%0d tms=%b rsp=%h expected 24 3 000 0",
                     lat, tck_cnt0 - c0, tms_log0[2:0], r);
        end
    endtask

    task automatic test_boundaries();
        logic [31:0] r; int lat; bit ok; int c0;
        run_cmd(0, OP_IR, 6'd4, 32'hE, r, lat, ok);
        checks++;
        if (!ok || r !== 32'h1) begin
            failures++; $display("FAIL bound_ir: got %h expected 1", r);
        end
        c0 = tck_cnt0;
        run_cmd(0, OP_DR, 6'd0, 32'h0, r, lat, ok);
        checks++;
        if (!ok || r !== 32'h1 || lat !== 48 || tck_cnt0 - c0 !== 6) begin
            failures++;
            $display("FAIL len0_as_1: got rsp=%h lat=%0d tcks=%0d expected 1 48 6", r, lat, tck_cnt0 - c0);
        end
        run_cmd(0, OP_DR, 6'd40, 32'h0, r, lat, ok);
        checks++;
        if (!ok || r !== IDCODE_VAL || lat !== 296) begin
            failures++; $display("FAIL len40_clamp: got rsp=%h lat=%0d expected 07926041 296", r, lat);
        end
    endtask

    task automatic test_clk_div1();
        logic [31:0] r; int lat; bit ok;
        run_cmd(1, OP_RST, 6'd0, 32'h0, r, lat, ok);
        checks++;
        if (!ok || lat !== 12) begin
            failures++; $display("FAIL div1_reset: got lat=%0d expected 12", lat);
        end
        run_cmd(1, OP_IR, 6'd4, 32'hE, r, lat, ok);
        checks++;
        if (!ok || r !== 32'h1 || lat !== 20) begin
            failures++; $display("FAIL div1_ir: got rsp=%h lat=%0d expected 1 20", r, lat);
        end
        run_cmd(1, OP_DR, 6'd32, 32'h0, r, lat, ok);
        checks++;
        if (!ok || r !== IDCODE_VAL || lat !== 74) begin
            failures++; $display("FAIL div1_idcode: got rsp=%h lat=%0d expected 07926041 74", r, lat);
        end
    endtask

    task automatic test_abort();
        logic [31:0] r; int lat; bit ok; int rc0;
        wait_ready(0);
        drive(0, 1'b1, OP_DR, 6'd32, 32'h0);
        @(negedge clk);
        drive(0, 1'b0, 2'b00, 6'd0, 32'h0);
        repeat (100) @(negedge clk);
        checks++;
        if (hif0.busy !== 1'b1) begin
            failures++; $display("FAIL abort_busy_before: got %b expected 1", hif0.busy);
        end
        rc0 = rsp_cnt;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({hif0.cmd_ready, hif0.busy, hif0.rsp_valid, tck_w[0], tms_w[0], tdi_w[0]} !== 6'b100010
            || hif0.rsp_data !== 32'h0) begin
            failures++;
            $display("FAIL abort_outputs: got %b rsp=%h expected 100010 rsp=0",
                     {hif0.cmd_ready, hif0.busy, hif0.rsp_valid, tck_w[0], tms_w[0], tdi_w[0]}, hif0.rsp_data);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (400) @(negedge clk);
        checks++;
        if (rsp_cnt !== rc0) begin
            failures++; $display("FAIL abort_no_rsp: got %0d pulses expected 0", rsp_cnt - rc0);
        end
        run_cmd(0, OP_RST, 6'd0, 32'h0, r, lat, ok);
        run_cmd(0, OP_IR, 6'd4, 32'hE, r, lat, ok);
        run_cmd(0, OP_DR, 6'd32, 32'h0, r, lat, ok);
        checks++;
        if (!ok || r !== IDCODE_VAL) begin
            failures++; $display("FAIL abort_recovery: got %h expected 07926041", r);
        end
    endtask

    initial begin
        drive(0, 1'b0, 2'b00, 6'd0, 32'h0);
        drive(1, 1'b0, 2'b00, 6'd0, 32'h0);
        test_reset();
        test_idcode();
        test_bypass();
        test_back_to_back();
        test_boundaries();
        test_clk_div1();
        test_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end
endmodule
